// File: rtl/step_clk_ctrl_if.sv
// Handshake bundle between the step clock controller and its environment.
// slave is the controller side, master is the board/core side.
interface step_clk_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             run_sw;
    logic             step_btn;
    logic             halt;
    logic             cpu_en;
    logic [1:0]       state;
    logic [CNT_W-1:0] en_count;

    modport slave (
        input  run_sw,
        input  step_btn,
        input  halt,
        output cpu_en,
        output state,
        output en_count
    );

    modport master (
        output run_sw,
        output step_btn,
        output halt,
        input  cpu_en,
        input  state,
        input  en_count
    );
endinterface

// File: rtl/step_clk_ctrl.sv
// Processor clock-enable controller: free-run or single-step cpu_en strobes on fastclk,
// with synchronised and debounced switch/button inputs and a halt stop.
module step_clk_ctrl #(
    parameter int unsigned DIV_N = 24,
    parameter int unsigned DB_N  = 16,
    parameter int unsigned CNT_W = 16
) (
    input logic            fastclk,
    input logic            n_reset,
    step_clk_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StRun    = 2'b01,
        StStep   = 2'b10,
        StHalted = 2'b11
    } state_e;

    logic             r_run_s1, r_run_s2, r_step_s1, r_step_s2;
    logic             r_run_db, r_step_db, r_step_db_q;
    logic [DB_N-1:0]  r_run_cnt, r_step_cnt;
    logic [DIV_N-1:0] r_presc;
    state_e           r_state;
    logic             r_cpu_en;
    logic [CNT_W-1:0] r_count;

    logic w_tick;
    logic w_step_rise;

    assign w_tick      = &r_presc;
    assign w_step_rise = r_step_db & ~r_step_db_q;

    always_ff @(posedge fastclk or negedge n_reset) begin
        if (!n_reset) begin
            r_run_s1  <= 1'b0;
            r_run_s2  <= 1'b0;
            r_step_s1 <= 1'b0;
            r_step_s2 <= 1'b0;
        end else begin
            r_run_s1  <= bus.run_sw;
            r_run_s2  <= r_run_s1;
            r_step_s1 <= bus.step_btn;
            r_step_s2 <= r_step_s1;
        end
    end

    // Accept a new level only after it has differed from the current one for 2**DB_N cycles.
    always_ff @(posedge fastclk or negedge n_reset) begin
        if (!n_reset) begin
            r_run_db  <= 1'b0;
            r_run_cnt <= '0;
        end else if (r_run_s2 == r_run_db) begin
            r_run_cnt <= '0;
        end else if (r_run_cnt == {DB_N{1'b1}}) begin
            r_run_db  <= r_run_s2;
            r_run_cnt <= '0;
        end else begin
            r_run_cnt <= r_run_cnt + 1'b1;
        end
    end

    always_ff @(posedge fastclk or negedge n_reset) begin
        if (!n_reset) begin
            r_step_db  <= 1'b0;
            r_step_cnt <= '0;
        end else if (r_step_s2 == r_step_db) begin
            r_step_cnt <= '0;
        end else if (r_step_cnt == {DB_N{1'b1}}) begin
            r_step_db  <= r_step_s2;
            r_step_cnt <= '0;
        end else begin
            r_step_cnt <= r_step_cnt + 1'b1;
        end
    end

    always_ff @(posedge fastclk or negedge n_reset) begin
        if (!n_reset) begin
            r_step_db_q <= 1'b0;
            r_presc     <= '0;
            r_count     <= '0;
        end else begin
            r_step_db_q <= r_step_db;
            r_presc     <= r_presc + 1'b1;
            if (r_cpu_en) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    always_ff @(posedge fastclk or negedge n_reset) begin
        if (!n_reset) begin
            r_state  <= StIdle;
            r_cpu_en <= 1'b0;
        end else begin
            r_cpu_en <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (r_run_db) begin
                        r_state <= StRun;
                    end else if (w_step_rise) begin
                        r_state  <= StStep;
                        r_cpu_en <= 1'b1;
                    end
                end
                StRun: begin
                    if (bus.halt) begin
                        r_state <= StHalted;
                    end else if (!r_run_db) begin
                        r_state <= StIdle;
                    end else begin
                        r_cpu_en <= w_tick;
                    end
                end
                StStep: begin
                    r_state <= bus.halt ? StHalted : StIdle;
                end
                StHalted: begin
                    if (!r_run_db && !r_step_db) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.cpu_en   = r_cpu_en;
    assign bus.state    = r_state;
    assign bus.en_count = r_count;

endmodule
